alu_pipe_param: RTL and testbench

Parametrised two-stage pipelined ALU, the next generation of the team's 8-bit add/sub/multiply ALU. Adds configurable width, logic ops and zero/carry/overflow flags. A valid/ready handshake with backpressure and a flush input let it sit directly between the decode stage and the writeback stage of the core. A user tag travels alongside each operation, so writeback matches results without a separate control delay line.

---
 rtl/alu_pipe_param_pkg.sv | 23 ++
 rtl/alu_pipe_stage_reg.sv | 21 ++
 rtl/alu_pipe_param.sv | 151 +++++++++++++++
 tb/tb_alu_pipe_param.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_param_pkg.sv
// Shared ALU definitions: opcode encodings and flag bit positions, also used by decode.
package alu_pipe_param_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL = 3'b101;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 2;

    // SUB is the only opcode that inverts B and injects a carry.
    function automatic logic is_sub(input logic [OP_W-1:0] op);
        return op == OP_SUB;
    endfunction

endpackage

// File: rtl/alu_pipe_stage_reg.sv
// Enabled pipeline data register with asynchronous clear.
module alu_pipe_stage_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_pipe_param.sv
// Two-stage pipelined ALU with valid/ready handshake, flush and passthrough tag.
module alu_pipe_param
    import alu_pipe_param_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [1:0]       hsel,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic [TAG_W-1:0] tag_out
);

    localparam int unsigned HW    = W / 2;
    localparam int unsigned QW    = W / 4;
    localparam int unsigned BHW   = HW - QW;
    localparam int unsigned PPL_W = HW + QW;
    localparam int unsigned PPH_W = HW + BHW;
    localparam int unsigned S1_W  = OP_W + TAG_W + (W + 1) + W + PPL_W + PPH_W + 2;
    localparam int unsigned S2_W  = W + FLAG_W + TAG_W;

    logic v1, v2, en1, en2;
    logic s1_load, s2_load;

    // Handshake: a stage advances when its successor can take its contents.
    assign en2       = !v2 || out_ready;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign out_valid = v2;
    assign s1_load   = in_valid && en1;
    assign s2_load   = en2 && v1;

    // Stage valid bits; flush wins over acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (in_valid && en1) begin
                v1 <= 1'b1;
            end else if (en1) begin
                v1 <= 1'b0;
            end
            if (en2) begin
                v2 <= v1;
            end
        end
    end

    logic             sub_c;
    logic [W-1:0]     b_x_c;
    logic [W-1:0]     logic_c;
    logic [W:0]       sum_c;
    logic [HW-1:0]    a_half_c;
    logic [HW-1:0]    b_half_c;
    logic [PPL_W-1:0] ppl_c;
    logic [PPH_W-1:0] pph_c;
    logic [S1_W-1:0]  s1_d, s1_q;

    // Stage 1 precompute: adder, logic op and split-B partial products.
    always_comb begin
        sub_c    = is_sub(op);
        b_x_c    = sub_c ? ~b : b;
        sum_c    = (W+1)'(a) + (W+1)'(b_x_c) + (W+1)'(sub_c);
        logic_c  = '0;
        case (op)
            OP_AND:  logic_c = a & b;
            OP_OR:   logic_c = a | b;
            OP_XOR:  logic_c = a ^ b;
            default: logic_c = '0;
        endcase
        a_half_c = hsel[1] ? a[W-1:HW] : a[HW-1:0];
        b_half_c = hsel[0] ? b[W-1:HW] : b[HW-1:0];
        ppl_c    = PPL_W'(a_half_c) * PPL_W'(b_half_c[QW-1:0]);
        pph_c    = PPH_W'(a_half_c) * PPH_W'(b_half_c[HW-1:QW]);
        s1_d     = {op, tag_in, sum_c, logic_c, ppl_c, pph_c, a[W-1], b_x_c[W-1]};
    end

    alu_pipe_stage_reg #(.WIDTH(S1_W)) u_s1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (s1_load),
        .d     (s1_d),
        .q     (s1_q)
    );

    logic [OP_W-1:0]   s1_op;
    logic [TAG_W-1:0]  s1_tag;
    logic [W:0]        s1_sum;
    logic [W-1:0]      s1_logic;
    logic [PPL_W-1:0]  s1_ppl;
    logic [PPH_W-1:0]  s1_pph;
    logic              s1_a_msb, s1_bx_msb;

    assign {s1_op, s1_tag, s1_sum, s1_logic, s1_ppl, s1_pph, s1_a_msb, s1_bx_msb} = s1_q;

    logic [W-1:0]      mul_c;
    logic [W-1:0]      res_c;
    logic [FLAG_W-1:0] flags_c;
    logic [S2_W-1:0]   s2_d, s2_q;

    // Stage 2: combine partial products, select result, derive flags.
    always_comb begin
        res_c   = '0;
        flags_c = '0;
        mul_c   = (W'(s1_pph) << QW) + W'(s1_ppl);
        case (s1_op)
            OP_AND, OP_OR, OP_XOR: res_c = s1_logic;
            OP_MUL:                res_c = mul_c;
            default: begin
                res_c          = s1_sum[W-1:0];
                flags_c[FLAG_C] = s1_sum[W];
                flags_c[FLAG_V] = (s1_a_msb == s1_bx_msb) && (s1_sum[W-1] != s1_a_msb);
            end
        endcase
        flags_c[FLAG_Z] = (res_c == '0);
        s2_d            = {res_c, flags_c, s1_tag};
    end

    alu_pipe_stage_reg #(.WIDTH(S2_W)) u_s2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (s2_load),
        .d     (s2_d),
        .q     (s2_q)
    );

    logic [FLAG_W-1:0] s2_flags;

    assign {result, s2_flags, tag_out} = s2_q;
    assign flag_z = s2_flags[FLAG_Z];
    assign flag_c = s2_flags[FLAG_C];
    assign flag_v = s2_flags[FLAG_V];

endmodule

// File: tb/tb_alu_pipe_param.sv
// Scoreboard bench for alu_pipe_param (W=8 main instance, W=16/TAG_W=6 logic-op instance).
module tb_alu_pipe_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, flush, out_valid, out_ready;
    logic [2:0] op;
    logic [1:0] hsel;
    logic [7:0] a, b, result;
    logic [3:0] tag_in, tag_out;
    logic       flag_z, flag_c, flag_v;

    logic        in_valid16, in_ready16, out_valid16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, result16;
    logic [5:0]  tag_in16, tag_out16;
    logic        flag_z16, flag_c16, flag_v16;

    alu_pipe_param #(.W(8), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .hsel(hsel), .a(a), .b(b), .tag_in(tag_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .tag_out(tag_out)
    );

    alu_pipe_param #(.W(16), .TAG_W(6)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .op(op16), .hsel(2'b00), .a(a16), .b(b16), .tag_in(tag_in16), .flush(1'b0),
        .out_valid(out_valid16), .out_ready(1'b1), .result(result16),
        .flag_z(flag_z16), .flag_c(flag_c16), .flag_v(flag_v16), .tag_out(tag_out16)
    );

    typedef struct packed {
        logic [7:0] res;
        logic [2:0] flg;   // {v, c, z}
        logic [3:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    int   cyc = 0;
    int   or_mode = 0;     // 0: ready, 1: stall window, 2: random, 3: held low
    int   st_lo = 0, st_hi = 0;
    bit   saw_block = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference behaviour of one W=8 operation.
    function automatic exp_t model(input logic [2:0] o, input logic [1:0] hs,
                                   input logic [7:0] aa, input logic [7:0] bb,
                                   input logic [3:0] tg);
        exp_t       e;
        logic [8:0] s;
        logic [7:0] bx;
        logic [3:0] ah, bh;
        e.tag = tg;
        e.flg = 3'b000;
        case (o)
            3'd2: e.res = aa & bb;
            3'd3: e.res = aa | bb;
            3'd4: e.res = aa ^ bb;
            3'd5: begin
                ah    = hs[1] ? aa[7:4] : aa[3:0];
                bh    = hs[0] ? bb[7:4] : bb[3:0];
                e.res = {4'b0, ah} * {4'b0, bh};
            end
            default: begin
                bx       = (o == 3'd1) ? ~bb : bb;
                s        = {1'b0, aa} + {1'b0, bx} + {8'b0, (o == 3'd1)};
                e.res    = s[7:0];
                e.flg[1] = s[8];
                e.flg[2] = (aa[7] == bx[7]) && (s[7] != aa[7]);
            end
        endcase
        e.flg[0] = (e.res == 8'h00);
        return e;
    endfunction

    // out_ready pattern generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (or_mode)
                1:       out_ready = !(cyc >= st_lo && cyc <= st_hi);
                2:       out_ready = ($urandom_range(0, 3) != 0);
                3:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops/compares outputs, holds stalled outputs, pushes accepted ops.
    initial begin
        exp_t       e;
        bit         prev_stall;
        logic [7:0] hold_res;
        logic [3:0] hold_tag;
        logic [2:0] hold_flg;
        prev_stall = 0;
        hold_res   = '0;
        hold_tag   = '0;
        hold_flg   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                prev_stall = 0;
            end else begin
                if (prev_stall && out_valid) begin
                    check("hold_result", 32'(result), 32'(hold_res));
                    check("hold_tag", 32'(tag_out), 32'(hold_tag));
                    check("hold_flags", 32'({flag_v, flag_c, flag_z}), 32'(hold_flg));
                end
                prev_stall = out_valid && !out_ready;
                hold_res   = result;
                hold_tag   = tag_out;
                hold_flg   = {flag_v, flag_c, flag_z};
                if (or_mode == 1 && in_valid && !in_ready) saw_block = 1;
                if (out_valid && out_ready) begin
                    check("sb_nonempty", 32'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("sb_result", 32'(result), 32'(e.res));
                        check("sb_flags", 32'({flag_v, flag_c, flag_z}), 32'(e.flg));
                        check("sb_tag", 32'(tag_out), 32'(e.tag));
                        popped++;
                    end
                end
                if (flush) sb_q.delete();
                else if (in_valid && in_ready) sb_q.push_back(model(op, hsel, a, b, tag_in));
            end
        end
    end

    // Present one op and wait (bounded) until it is accepted.
    task automatic send(input logic [2:0] o, input logic [1:0] hs, input logic [7:0] aa,
                        input logic [7:0] bb, input logic [3:0] tg);
        bit acc;
        int n;
        op = o; hsel = hs; a = aa; b = bb; tag_in = tg; in_valid = 1'b1;
        acc = 0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("send_accept", 32'(acc), 1);
    endtask

    // Single op on an idle pipe with out_ready high: exact 2-cycle latency and values.
    task automatic run_single(input string name, input logic [2:0] o, input logic [1:0] hs,
                              input logic [7:0] aa, input logic [7:0] bb, input logic [3:0] tg,
                              input logic [7:0] er, input logic [2:0] ef);
        op = o; hsel = hs; a = aa; b = bb; tag_in = tg; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({name, "_lat1"}, 32'(out_valid), 0);
        @(posedge clk);
        #1;
        check({name, "_lat2"}, 32'(out_valid), 1);
        check({name, "_res"}, 32'(result), 32'(er));
        check({name, "_flg"}, 32'({flag_v, flag_c, flag_z}), 32'(ef));
        check({name, "_tag"}, 32'(tag_out), 32'(tg));
    endtask

    // Wait (bounded) until the scoreboard and pipe are empty.
    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(sb_q.size()), 0);
    endtask

    task automatic op16_check(input string name, input logic [2:0] o, input logic [15:0] aa,
                              input logic [15:0] bb, input logic [5:0] tg, input logic [15:0] er);
        op16 = o; a16 = aa; b16 = bb; tag_in16 = tg; in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_valid"}, 32'(out_valid16), 1);
        check({name, "_res"}, 32'(result16), 32'(er));
        check({name, "_z"}, 32'(flag_z16), 32'(er == 16'h0000));
        check({name, "_cv"}, 32'({flag_c16, flag_v16}), 0);
        check({name, "_tag"}, 32'(tag_out16), 32'(tg));
    endtask

    initial begin
        int p0;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        op = '0; hsel = '0; a = '0; b = '0; tag_in = '0;
        in_valid16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; tag_in16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_result", 32'(result), 0);
        check("rst_flags", 32'({flag_v, flag_c, flag_z}), 0);
        check("rst_tag", 32'(tag_out), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed values.
        run_single("add_7f_01", 3'd0, 2'b00, 8'h7F, 8'h01, 4'd1, 8'h80, 3'b100);
        run_single("sub_eq",    3'd1, 2'b00, 8'h05, 8'h05, 4'd2, 8'h00, 3'b011);
        run_single("sub_borrow",3'd1, 2'b00, 8'h00, 8'h01, 4'd3, 8'hFF, 3'b000);
        run_single("mul_hi_lo", 3'd5, 2'b10, 8'hA3, 8'h5C, 4'd4, 8'h78, 3'b000);
        run_single("mul_lo_hi", 3'd5, 2'b01, 8'hA3, 8'h5C, 4'd5, 8'h0F, 3'b000);
        run_single("add_wrap",  3'd0, 2'b00, 8'hFF, 8'h01, 4'd6, 8'h00, 3'b011);
        run_single("sub_ovf",   3'd1, 2'b00, 8'h80, 8'h01, 4'd7, 8'h7F, 3'b110);
        run_single("rsvd_add",  3'd6, 2'b00, 8'h10, 8'h01, 4'd8, 8'h11, 3'b000);
        run_single("xor_zero",  3'd4, 2'b00, 8'h5A, 8'h5A, 4'd9, 8'h00, 3'b001);
        run_single("mul_max",   3'd5, 2'b11, 8'hF0, 8'hF0, 4'd10, 8'hE1, 3'b000);
        drain();

        // Back-to-back stream with a 3-cycle stall.
        p0 = popped;
        saw_block = 0;
        st_lo = cyc + 3;
        st_hi = cyc + 5;
        or_mode = 1;
        for (int i = 0; i < 6; i++) send(3'd0, 2'b00, 8'(i * 16 + 1), 8'(i), 4'(i));
        drain();
        or_mode = 0;
        check("stall_inready_drop", 32'(saw_block), 1);
        check("stream_count", 32'(popped - p0), 6);

        // Flush with two ops in flight and a third presented.
        or_mode = 3;
        out_ready = 1'b0;
        send(3'd0, 2'b00, 8'h11, 8'h22, 4'hA);
        send(3'd0, 2'b00, 8'h33, 8'h44, 4'hB);
        op = 3'd0; a = 8'h55; b = 8'h66; tag_in = 4'hC; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        or_mode = 0;
        out_ready = 1'b1;
        check("flush_out_valid", 32'(out_valid), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("flush_quiet", 32'(out_valid), 0);
        end
        run_single("post_flush", 3'd3, 2'b00, 8'h0C, 8'h30, 4'hD, 8'h3C, 3'b000);
        drain();

        // Asynchronous reset mid-stream.
        op = 3'd0; a = 8'h10; b = 8'h20; tag_in = 4'h7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h01; b = 8'h02; tag_in = 4'h8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_result", 32'(result), 0);
        check("arst_flags", 32'({flag_v, flag_c, flag_z}), 0);
        check("arst_tag", 32'(tag_out), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_out_valid", 32'(out_valid), 0);
        run_single("post_rst", 3'd2, 2'b00, 8'hF3, 8'h3F, 4'h2, 8'h33, 3'b000);
        drain();

        // Randomised traffic with random backpressure.
        or_mode = 2;
        p0 = popped;
        for (int i = 0; i < 40; i++)
            send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom),
                 8'($urandom), 4'(i));
        drain();
        or_mode = 0;
        check("random_count", 32'(popped - p0), 40);

        // W=16, TAG_W=6 logic-op regression.
        op16_check("w16_and",  3'd2, 16'hF0F0, 16'h0FF0, 6'd33, 16'h00F0);
        op16_check("w16_or",   3'd3, 16'hF0F0, 16'h0FF0, 6'd34, 16'hFFF0);
        op16_check("w16_xor",  3'd4, 16'hF0F0, 16'h0FF0, 6'd35, 16'hFF00);
        op16_check("w16_andz", 3'd2, 16'hF0F0, 16'h0F0F, 6'd63, 16'h0000);
        check("w16_in_ready", 32'(in_ready16), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
